// File: rtl/video_timing_pkg.sv
// Shared video timing defaults, pixel field layout and output FSM states.
// Imported by the video output block and its pixel FIFO.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE   = 1280;
  localparam int DEF_H_FP       = 110;
  localparam int DEF_H_SYNC     = 40;
  localparam int DEF_H_BP       = 220;
  localparam int DEF_V_ACTIVE   = 720;
  localparam int DEF_V_FP       = 5;
  localparam int DEF_V_SYNC     = 5;
  localparam int DEF_V_BP       = 20;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam int PIX_W = 24;
  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  localparam int TLAST_BIT = 24;
  localparam int TUSER_BIT = 25;
  localparam int FIFO_W    = 26;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } vout_state_e;

  function automatic logic [PIX_W-1:0] rgb(
    input logic [PIX_W-1:0] d
  );
    return {d[R_MSB:R_LSB], d[G_MSB:G_LSB], d[B_MSB:B_LSB]};
  endfunction

endpackage

// File: rtl/axis_video_out_pix_fifo.sv
// Synchronous first-word-fall-through FIFO with flush.
// A push in the flush cycle lands as the only entry.
module pix_fifo
  import video_timing_pkg::*;
#(
  parameter int WIDTH = FIFO_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             we;
  logic             re;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign we    = push && (flush || !full);
  assign re    = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (we) mem[flush ? '0 : wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= we ? AW'(1) : '0;
      count  <= we ? (AW+1)'(1) : '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (re) rd_ptr <= rd_ptr + 1'b1;
      unique case ({we, re})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_video_out.sv
// AXI4-Stream to raster video: free-running timing, FIFO-fed pixels,
// frame-locked start with underflow/SOF/EOL error recovery.
module axis_video_out
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic [PIX_W-1:0] vid_data,
  output logic             vid_active,
  output logic             vid_hsync,
  output logic             vid_vsync,
  output logic             underflow,
  output logic             sof_err,
  output logic             eol_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EOL  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  vout_state_e       state;
  vout_state_e       state_n;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              active;
  logic              first_pix;
  logic              frame_end;
  logic              rdy_en;
  logic              hs_in;
  logic              push;
  logic              pop;
  logic              flush;
  logic              full;
  logic              empty;
  logic              set_uf;
  logic              set_sof;
  logic              set_eol;
  logic [FIFO_W-1:0] din;
  logic [FIFO_W-1:0] dout;
  logic [PIX_W-1:0]  pix_n;

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign first_pix = (h_cnt == '0) && (v_cnt == '0);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign din       = {s_axis_tuser, s_axis_tlast, s_axis_tdata};

  // rdy_en keeps tready low through reset and its release cycle
  assign s_axis_tready = rdy_en && ((state == IDLE) || !full);
  assign hs_in         = s_axis_tvalid && s_axis_tready;

  pix_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pixel_clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n = state;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    set_uf  = 1'b0;
    set_sof = 1'b0;
    set_eol = 1'b0;
    pix_n   = '0;
    unique case (state)
      IDLE: begin
        if (hs_in && s_axis_tuser) begin
          push    = 1'b1;
          state_n = FILL;
        end
      end
      FILL: begin
        push = hs_in;
        if (frame_end) state_n = RUN;
      end
      RUN: begin
        push = hs_in;
        if (active) begin
          if (empty) begin
            set_uf  = 1'b1;
            flush   = 1'b1;
            state_n = IDLE;
          end else if (dout[TUSER_BIT] != first_pix) begin
            set_sof = 1'b1;
            flush   = 1'b1;
            state_n = IDLE;
          end else begin
            pop     = 1'b1;
            pix_n   = rgb(dout[PIX_W-1:0]);
            set_eol = (dout[TLAST_BIT] != (h_cnt == H_EOL));
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // a start-of-frame beat arriving with the flush restarts the fill
    if (flush) begin
      push = hs_in && s_axis_tuser;
      if (push) state_n = FILL;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rdy_en     <= 1'b0;
      vid_data   <= '0;
      vid_active <= 1'b0;
      vid_hsync  <= 1'b0;
      vid_vsync  <= 1'b0;
      underflow  <= 1'b0;
      sof_err    <= 1'b0;
      eol_err    <= 1'b0;
    end else begin
      state      <= state_n;
      rdy_en     <= 1'b1;
      vid_data   <= pix_n;
      vid_active <= active;
      vid_hsync  <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vid_vsync  <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
      underflow  <= underflow | set_uf;
      sof_err    <= sof_err | set_sof;
      eol_err    <= eol_err | set_eol;
    end
  end

endmodule

// File: tb/tb_axis_video_out.sv
// Directed bench for axis_video_out on a 14x7 raster (8x4 active).
// Pixels seen on active cycles are checked against hand-built frames.
module tb_axis_video_out;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic [23:0] vid_data;
  logic        vid_active;
  logic        vid_hsync;
  logic        vid_vsync;
  logic        underflow;
  logic        sof_err;
  logic        eol_err;

  int n_chk = 0;
  int n_pass = 0;

  logic [24:0] cap_q[$];
  logic [24:0] exp_q[$];

  always #5 clk = ~clk;

  axis_video_out #(
    .H_ACTIVE   (8),
    .H_FP       (2),
    .H_SYNC     (2),
    .H_BP       (2),
    .V_ACTIVE   (4),
    .V_FP       (1),
    .V_SYNC     (1),
    .V_BP       (1),
    .FIFO_DEPTH (16)
  ) dut (
    .pixel_clk     (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tuser  (tuser),
    .s_axis_tlast  (tlast),
    .vid_data      (vid_data),
    .vid_active    (vid_active),
    .vid_hsync     (vid_hsync),
    .vid_vsync     (vid_vsync),
    .underflow     (underflow),
    .sof_err       (sof_err),
    .eol_err       (eol_err)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_beat(
    input logic [23:0] d,
    input logic        u,
    input logic        l
  );
    int n;
    n = 0;
    @(negedge clk);
    tdata  = d;
    tuser  = u;
    tlast  = l;
    tvalid = 1'b1;
    while (!tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("tready_timeout", 32'(tready), 1);
  endtask

  task automatic end_beats();
    @(negedge clk);
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
  endtask

  // eol_pos picks which beat of line 0 carries tlast (7 is correct)
  task automatic send_frame(
    input logic [23:0] base,
    input int          eol_pos
  );
    logic l;
    for (int i = 0; i < 32; i++) begin
      l = ((i % 8) == 7);
      if (i < 8) l = (i == eol_pos);
      send_beat(base + 24'(i), i == 0, l);
    end
    end_beats();
  endtask

  task automatic capture(input int nf);
    repeat (nf * FR) begin
      @(negedge clk);
      if (vid_active) cap_q.push_back({underflow, vid_data});
    end
  endtask

  task automatic exp_black(input int n, input logic uf);
    for (int i = 0; i < n; i++) exp_q.push_back({uf, 24'h0});
  endtask

  task automatic exp_seq(
    input logic [23:0] base,
    input int          first,
    input int          n,
    input logic        uf
  );
    for (int i = first; i < first + n; i++)
      exp_q.push_back({uf, base + 24'(i)});
  endtask

  task automatic compare(input string tag);
    chk({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_px%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [26:0] t_exp;
    int          h;
    int          v;
    int          n;

    // reset state and tready release
    repeat (2) @(negedge clk);
    chk("rst_timing", {vid_active, vid_hsync, vid_vsync}, 0);
    chk("rst_flags", {underflow, sof_err, eol_err}, 0);
    chk("rst_data", vid_data, 0);
    chk("rst_ready", 32'(tready), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(tready), 1);

    // idle raster, one full frame
    do_reset();
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      h = k % HT;
      v = k / HT;
      t_exp = {(h < 8) && (v < 4), (h >= 10) && (h < 12), v == 5, 24'h0};
      chk($sformatf("idle_h%0d_v%0d", h, v),
          {vid_active, vid_hsync, vid_vsync, vid_data}, 32'(t_exp));
    end

    // good frame shows on the following frame
    do_reset();
    fork
      send_frame(24'h0, 7);
      capture(2);
    join
    exp_black(32, 1'b0);
    exp_seq(24'h0, 0, 32, 1'b0);
    compare("good");
    chk("good_flags", {underflow, sof_err, eol_err}, 0);

    // short frame underflows, next SOF frame recovers
    do_reset();
    fork
      begin
        for (int i = 0; i < 20; i++)
          send_beat(24'(i), i == 0, (i % 8) == 7);
        end_beats();
        n = 0;
        while (!underflow && n < 400) begin
          @(negedge clk);
          n++;
        end
        chk("uf_seen", 32'(underflow), 1);
        send_frame(24'hA00000, 7);
      end
      capture(3);
    join
    exp_black(32, 1'b0);
    exp_seq(24'h0, 0, 20, 1'b0);
    exp_black(12, 1'b1);
    exp_seq(24'hA00000, 0, 32, 1'b1);
    compare("uf");
    chk("uf_other_flags", {sof_err, eol_err}, 0);

    // garbage before SOF is swallowed
    do_reset();
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          send_beat(24'h5A0000 + 24'(i), 1'b0, 1'b0);
          chk($sformatf("garbage_ready%0d", i), 32'(tready), 1);
        end
        send_frame(24'h0, 7);
      end
      capture(2);
    join
    exp_black(32, 1'b0);
    exp_seq(24'h0, 0, 32, 1'b0);
    compare("garbage");
    chk("garbage_flags", {underflow, sof_err, eol_err}, 0);

    // tlast early on line 0
    do_reset();
    fork
      send_frame(24'h0, 5);
      capture(2);
    join
    exp_black(32, 1'b0);
    exp_seq(24'h0, 0, 32, 1'b0);
    compare("eol");
    chk("eol_flags", {underflow, sof_err, eol_err}, 3'b001);

    // asynchronous reset mid-frame clears sticky flags at once
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_flags", {underflow, sof_err, eol_err}, 0);
    chk("midrst_timing", {vid_active, vid_hsync, vid_vsync}, 0);
    do_reset();
    @(negedge clk);
    chk("restart_first_px", {vid_active, vid_hsync, vid_vsync}, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
